// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV32I writeback stage: load extraction, x0 filtering, retire count
module wb_stage #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGISTER = 32,
    localparam int AW          = $clog2(NUM_REGISTER)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  reg_write_i,
    input  logic                  is_load_i,
    input  logic [2:0]            funct3_i,
    input  logic [1:0]            addr_lo_i,
    input  logic [DATA_WIDTH-1:0] result_i,
    input  logic [AW-1:0]         rd_addr_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  we_o,
    output logic [AW-1:0]         rd_addr_o,
    output logic [DATA_WIDTH-1:0] rd_o,
    output logic                  err_o,
    output logic [31:0]           retired_o
);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_e;

    state_e                state_q, state_d;
    logic                  reg_write_q, reg_write_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [AW-1:0]         rd_addr_q, rd_addr_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic [AW-1:0]         rd_addr_o_q, rd_addr_o_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic [31:0]           retired_q, retired_d;

    logic                  accept;
    logic                  load_bad;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_data;

    assign ready_o = !rst_i && (state_q != WAIT_MEM);
    assign accept  = valid_i && ready_o;

    // Misaligned loads never reach memory, so they must bypass WAIT_MEM.
    always_comb begin
        load_bad = 1'b0;
        case (funct3_i)
            3'b000, 3'b100: load_bad = 1'b0;
            3'b001, 3'b101: load_bad = addr_lo_i[0];
            3'b010:         load_bad = (addr_lo_i != 2'b00);
            default:        load_bad = 1'b1;
        endcase
    end

    always_comb begin
        ld_byte = 8'h00;
        case (addr_lo_q)
            2'd0: ld_byte = mem_rdata_i[7:0];
            2'd1: ld_byte = mem_rdata_i[15:8];
            2'd2: ld_byte = mem_rdata_i[23:16];
            2'd3: ld_byte = mem_rdata_i[31:24];
            default: ld_byte = 8'h00;
        endcase
        ld_half = addr_lo_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        ld_data = mem_rdata_i;
        case (funct3_q)
            3'b000:  ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: ld_data = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        reg_write_d = reg_write_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        rd_addr_d   = rd_addr_q;
        we_d        = 1'b0;
        err_d       = 1'b0;
        rd_addr_o_d = rd_addr_o_q;
        rd_d        = rd_q;
        retired_d   = retired_q;
        case (state_q)
            IDLE, WRITE: begin
                if (accept) begin
                    reg_write_d = reg_write_i;
                    funct3_d    = funct3_i;
                    addr_lo_d   = addr_lo_i;
                    rd_addr_d   = rd_addr_i;
                    if (!is_load_i) begin
                        state_d   = WRITE;
                        we_d      = reg_write_i && (rd_addr_i != '0);
                        retired_d = retired_q + 32'd1;
                        if (we_d) begin
                            rd_addr_o_d = rd_addr_i;
                            rd_d        = result_i;
                        end
                    end else if (load_bad) begin
                        state_d = WRITE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = WAIT_MEM;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid_i) begin
                    state_d   = WRITE;
                    we_d      = reg_write_q && (rd_addr_q != '0);
                    retired_d = retired_q + 32'd1;
                    if (we_d) begin
                        rd_addr_o_d = rd_addr_q;
                        rd_d        = ld_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            reg_write_q <= 1'b0;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            rd_addr_q   <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            rd_addr_o_q <= '0;
            rd_q        <= '0;
            retired_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            reg_write_q <= reg_write_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            rd_addr_q   <= rd_addr_d;
            we_q        <= we_d;
            err_q       <= err_d;
            rd_addr_o_q <= rd_addr_o_d;
            rd_q        <= rd_d;
            retired_q   <= retired_d;
        end
    end

    assign we_o      = we_q;
    assign err_o     = err_q;
    assign rd_addr_o = rd_addr_o_q;
    assign rd_o      = rd_q;
    assign retired_o = retired_q;

endmodule
